// File: rtl/mips_pkg.sv
// Shared encodings and constants for the multicycle MIPS datapath blocks.
package mips_pkg;

  typedef enum logic [1:0] {
    MODO_SEQ    = 2'd0,
    MODO_BRANCH = 2'd1,
    MODO_JUMP   = 2'd2,
    MODO_REG    = 2'd3
  } modo_e;

  localparam int unsigned INCREMENTO_PC = 4;
  localparam int unsigned LARGURA_ETAPA = 4;

endpackage

// File: rtl/contador_etapas.sv
// Modulo-NUM_ETAPAS step counter with enable and synchronous reset.
// Kept generic so the control unit can instantiate its own copy.
module contador_etapas
  import mips_pkg::*;
#(
  parameter int unsigned NUM_ETAPAS = 5,
  parameter int unsigned LARGURA    = LARGURA_ETAPA
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  output logic [LARGURA-1:0] etapa_o
);

  localparam logic [LARGURA-1:0] ULTIMA = LARGURA'(NUM_ETAPAS - 1);

  logic [LARGURA-1:0] etapa_q, etapa_d;

  always_comb begin
    etapa_d = etapa_q;
    if (en_i) begin
      etapa_d = (etapa_q == ULTIMA) ? '0 : etapa_q + LARGURA'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) etapa_q <= '0;
    else       etapa_q <= etapa_d;
  end

  assign etapa_o = etapa_q;

endmodule

// File: rtl/contador_programa_multiciclo.sv
// Multicycle MIPS program counter: owns the instruction step counter and
// loads the next address once per instruction, in step ETAPA_CARGA.
module contador_programa_multiciclo
  import mips_pkg::*;
#(
  parameter int unsigned          LARGURA      = 32,
  parameter int unsigned          NUM_ETAPAS   = 5,
  parameter int unsigned          ETAPA_CARGA  = 1,
  parameter logic [LARGURA-1:0]   RESET_VECTOR = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     habilita,
  input  logic [1:0]               modo,
  input  logic                     condicao,
  input  logic [15:0]              deslocamento,
  input  logic [25:0]              alvoJump,
  input  logic [LARGURA-1:0]       endEntrada,
  output logic [LARGURA-1:0]       endSaida,
  output logic [LARGURA-1:0]       pcMais4,
  output logic [LARGURA_ETAPA-1:0] etapa,
  output logic                     excecaoAlinhamento
);

  localparam logic [LARGURA_ETAPA-1:0] ETAPA_CARGA_L = LARGURA_ETAPA'(ETAPA_CARGA);

  logic [LARGURA-1:0] pc_q, pc_d;
  logic               exc_q, exc_d;
  logic [LARGURA-1:0] alvo_branch, alvo_jump, desl_ext;
  logic               carga;

  contador_etapas #(
    .NUM_ETAPAS (NUM_ETAPAS),
    .LARGURA    (LARGURA_ETAPA)
  ) u_etapas (
    .clk_i   (clk),
    .rst_i   (rst),
    .en_i    (habilita),
    .etapa_o (etapa)
  );

  assign pcMais4     = pc_q + LARGURA'(INCREMENTO_PC);
  // Word offset -> byte offset; sign bit replicated across the upper bits.
  assign desl_ext    = {{(LARGURA-18){deslocamento[15]}}, deslocamento, 2'b00};
  assign alvo_branch = pcMais4 + desl_ext;
  assign alvo_jump   = {pcMais4[LARGURA-1:28], alvoJump, 2'b00};
  assign carga       = habilita && (etapa == ETAPA_CARGA_L);

  always_comb begin
    pc_d  = pc_q;
    exc_d = exc_q;
    if (carga) begin
      case (modo)
        MODO_SEQ:    pc_d = pcMais4;
        MODO_BRANCH: pc_d = condicao ? alvo_branch : pcMais4;
        MODO_JUMP:   pc_d = alvo_jump;
        MODO_REG: begin
          // Misaligned jr target: keep PC, latch the sticky fault.
          if (endEntrada[1:0] == 2'b00) pc_d  = endEntrada;
          else                          exc_d = 1'b1;
        end
        default:     pc_d = pc_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= RESET_VECTOR;
      exc_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      exc_q <= exc_d;
    end
  end

  assign endSaida           = pc_q;
  assign excecaoAlinhamento = exc_q;

endmodule

// File: tb/tb_contador_programa_multiciclo.sv
// Directed scoreboard bench for the multicycle program counter (defaults:
// 32-bit PC, 5 steps, load in step 1, reset vector 0).
module tb_contador_programa_multiciclo;

  typedef struct {
    logic [31:0] pc;
    logic [3:0]  et;
    logic        fl;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, habilita, condicao;
  logic [1:0]  modo;
  logic [15:0] deslocamento;
  logic [25:0] alvoJump;
  logic [31:0] endEntrada;
  logic [31:0] endSaida, pcMais4;
  logic [3:0]  etapa;
  logic        excecaoAlinhamento;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_pc;
  logic [3:0]  exp_et;
  logic        exp_fl;

  always #5 clk = ~clk;

  contador_programa_multiciclo dut (
    .clk                (clk),
    .rst                (rst),
    .habilita           (habilita),
    .modo               (modo),
    .condicao           (condicao),
    .deslocamento       (deslocamento),
    .alvoJump           (alvoJump),
    .endEntrada         (endEntrada),
    .endSaida           (endSaida),
    .pcMais4            (pcMais4),
    .etapa              (etapa),
    .excecaoAlinhamento (excecaoAlinhamento)
  );

  // Monitor: every clock produces one observable state; compare it against
  // the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks += 4;
        if (endSaida !== e.pc) begin
          errors++;
          $display("FAIL endSaida got=%h exp=%h t=%0t", endSaida, e.pc, $time);
        end
        if (pcMais4 !== e.pc + 32'd4) begin
          errors++;
          $display("FAIL pcMais4 got=%h exp=%h t=%0t", pcMais4, e.pc + 32'd4, $time);
        end
        if (etapa !== e.et) begin
          errors++;
          $display("FAIL etapa got=%0d exp=%0d t=%0t", etapa, e.et, $time);
        end
        if (excecaoAlinhamento !== e.fl) begin
          errors++;
          $display("FAIL excecao got=%b exp=%b t=%0t", excecaoAlinhamento, e.fl, $time);
        end
      end
    end
  end

  task automatic drive(input logic r, input logic h, input logic [1:0] m,
                       input logic c, input logic [15:0] d,
                       input logic [25:0] a, input logic [31:0] en);
    exp_t t;
    @(negedge clk);
    rst = r; habilita = h; modo = m; condicao = c;
    deslocamento = d; alvoJump = a; endEntrada = en;
    t.pc = exp_pc; t.et = exp_et; t.fl = exp_fl;
    sb.push_back(t);
  endtask

  // n enabled cycles with the given inputs; caller sets exp_pc beforehand
  // for the cycle that is a load step.
  task automatic tick(input int n, input logic [1:0] m, input logic c,
                      input logic [15:0] d, input logic [25:0] a,
                      input logic [31:0] en);
    for (int i = 0; i < n; i++) begin
      exp_et = (exp_et == 4'd4) ? 4'd0 : exp_et + 4'd1;
      drive(1'b0, 1'b1, m, c, d, a, en);
    end
  endtask

  initial begin
    int budget;
    rst = 1'b1; habilita = 1'b0; modo = 2'd0; condicao = 1'b0;
    deslocamento = '0; alvoJump = '0; endEntrada = '0;
    exp_pc = 32'h0; exp_et = 4'd0; exp_fl = 1'b0;

    // Reset wins even over a misaligned jr request.
    drive(1'b1, 1'b1, 2'd3, 1'b1, 16'hFFFE, 26'h0, 32'h102);
    drive(1'b1, 1'b1, 2'd3, 1'b1, 16'hFFFE, 26'h0, 32'h102);

    // Sequential: loads only on etapa 1 edges.
    tick(1, 2'd0, 1'b0, 16'h0, 26'h0, 32'h0);            // et1 pc0
    exp_pc = 32'h4;  tick(1, 2'd0, 1'b0, 16'h0, 26'h0, 32'h0);
    tick(4, 2'd0, 1'b0, 16'h0, 26'h0, 32'h0);            // et3,4,0,1
    exp_pc = 32'h8;  tick(1, 2'd0, 1'b0, 16'h0, 26'h0, 32'h0);

    // jr inputs outside the load step are ignored; then jr to 0x10.
    tick(4, 2'd3, 1'b0, 16'h0, 26'h0, 32'h10);
    exp_pc = 32'h10; tick(1, 2'd3, 1'b0, 16'h0, 26'h0, 32'h10);

    // Taken branch -2 words: 0x14 - 8 = 0xC.
    tick(4, 2'd1, 1'b1, 16'hFFFE, 26'h0, 32'h0);
    exp_pc = 32'hC;  tick(1, 2'd1, 1'b1, 16'hFFFE, 26'h0, 32'h0);
    tick(4, 2'd0, 1'b0, 16'h0, 26'h0, 32'h0);
    exp_pc = 32'h10; tick(1, 2'd3, 1'b0, 16'h0, 26'h0, 32'h10);
    // Not-taken branch.
    tick(4, 2'd1, 1'b0, 16'hFFFE, 26'h0, 32'h0);
    exp_pc = 32'h14; tick(1, 2'd1, 1'b0, 16'hFFFE, 26'h0, 32'h0);

    // J-type from 0x40000000.
    tick(4, 2'd0, 1'b0, 16'h0, 26'h0, 32'h0);
    exp_pc = 32'h4000_0000; tick(1, 2'd3, 1'b0, 16'h0, 26'h0, 32'h4000_0000);
    tick(4, 2'd2, 1'b0, 16'h0, 26'h100, 32'h0);
    exp_pc = 32'h4000_0400; tick(1, 2'd2, 1'b0, 16'h0, 26'h100, 32'h0);

    // Stall 3 cycles in etapa 1 with a misaligned jr pending: nothing moves.
    tick(4, 2'd0, 1'b0, 16'h0, 26'h0, 32'h0);
    repeat (3) drive(1'b0, 1'b0, 2'd3, 1'b0, 16'h0, 26'h0, 32'h102);
    exp_pc = 32'h4000_0404; tick(1, 2'd0, 1'b0, 16'h0, 26'h0, 32'h0);

    // Misaligned jr: PC holds, flag sets and stays through valid loads.
    tick(4, 2'd0, 1'b0, 16'h0, 26'h0, 32'h0);
    exp_fl = 1'b1;   tick(1, 2'd3, 1'b0, 16'h0, 26'h0, 32'h102);
    tick(4, 2'd0, 1'b0, 16'h0, 26'h0, 32'h0);
    exp_pc = 32'hFFFF_FFFC; tick(1, 2'd3, 1'b0, 16'h0, 26'h0, 32'hFFFF_FFFC);

    // Wrap-around 0xFFFFFFFC + 4 = 0.
    tick(4, 2'd0, 1'b0, 16'h0, 26'h0, 32'h0);
    exp_pc = 32'h0;  tick(1, 2'd0, 1'b0, 16'h0, 26'h0, 32'h0);
    tick(4, 2'd0, 1'b0, 16'h0, 26'h0, 32'h0);
    exp_pc = 32'h4;  tick(1, 2'd0, 1'b0, 16'h0, 26'h0, 32'h0);
    tick(1, 2'd0, 1'b0, 16'h0, 26'h0, 32'h0);            // et3

    // Reset mid-instruction aborts it and clears the flag.
    exp_pc = 32'h0; exp_et = 4'd0; exp_fl = 1'b0;
    drive(1'b1, 1'b1, 2'd0, 1'b0, 16'h0, 26'h0, 32'h0);
    tick(1, 2'd0, 1'b0, 16'h0, 26'h0, 32'h0);
    exp_pc = 32'h4;  tick(1, 2'd0, 1'b0, 16'h0, 26'h0, 32'h0);
    tick(1, 2'd0, 1'b0, 16'h0, 26'h0, 32'h0);
    // Reset also wins over habilita=0.
    exp_pc = 32'h0; exp_et = 4'd0;
    drive(1'b1, 1'b0, 2'd0, 1'b0, 16'h0, 26'h0, 32'h0);
    drive(1'b0, 1'b0, 2'd0, 1'b0, 16'h0, 26'h0, 32'h0);

    budget = 20;
    while (sb.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending=%0d exp=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
